ring_tune_ctrl: RTL and testbench
=================================

RING_TUNE_CTRL -- requirements
Module: ring_tune_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHANNEL, default 8: number of rings in the row being tuned.
REQ-002 SHALL have parameter TUNE_WIDTH, default 8: tuning-code width per ring.
REQ-003 SHALL have parameter PWR_WIDTH, default 10: drop-power ADC code width.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 4: thermal settle wait after each code change (>=1).
REQ-005 SHALL have parameter LOCK_THRESH, default 16: minimum peak power for a ring to count as locked.
REQ-006 SHALL have port i_clk, input, 1: the single clock.
REQ-007 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port i_start, input, 1: single-cycle pulse that begins calibration.
REQ-009 SHALL have port o_pwr_req, output, 1: request for one drop-power sample.
REQ-010 SHALL have port o_pwr_sel, output, $clog2(NUM_CHANNEL): index of the drop port to sample.
REQ-011 SHALL have port i_pwr_valid, input, 1: the sample on i_pwr_code is valid.
REQ-012 SHALL have port i_pwr_code, input, PWR_WIDTH: unsigned drop-port power.
REQ-013 SHALL have port o_tune_code, output, NUM_CHANNEL x TUNE_WIDTH: per-ring tuning code.
REQ-014 SHALL have port o_lock, output, NUM_CHANNEL: per-ring lock flag.
REQ-015 SHALL have ports o_busy and o_done, outputs, 1 bit each: calibration running / calibration complete.

Function
REQ-016 SHALL use FSM states IDLE, SETTLE, MEASURE, COMMIT, DONE.
REQ-017 SHALL move IDLE->SETTLE on i_start, with channel=0, code=0, best_pwr=0, best_code=0; SHALL ignore i_start in all other states except DONE, where it restarts calibration.
REQ-018 SHALL hold SETTLE for exactly SETTLE_CYCLES cycles, then move to MEASURE.
REQ-019 SHALL assert o_pwr_req throughout MEASURE; a sample SHALL be accepted only in a cycle with o_pwr_req and i_pwr_valid both high; i_pwr_valid outside MEASURE SHALL be ignored.
REQ-020 SHALL replace best_pwr/best_code on an accepted sample only if i_pwr_code > best_pwr (strictly greater), so the lowest code wins a tie.
REQ-021 On an accepted sample with code < 2^TUNE_WIDTH-1, SHALL increment the code, drive it on o_tune_code[channel] in the next cycle, and return to SETTLE; the code counter SHALL never wrap.
REQ-022 On an accepted sample at code 2^TUNE_WIDTH-1, SHALL go to COMMIT, which lasts one cycle.
REQ-023 COMMIT SHALL set o_tune_code[channel]=best_code and o_lock[channel]=(best_pwr>=LOCK_THRESH); a sample accepted at the final code SHALL be included in that comparison.
REQ-024 After COMMIT SHALL go to SETTLE for channel+1 with code/best cleared, or to DONE after channel NUM_CHANNEL-1.
REQ-025 SHALL drive o_pwr_sel with the current channel; rings not yet swept SHALL hold code 0, and swept rings SHALL hold their committed code.
REQ-026 SHALL hold o_busy high in SETTLE, MEASURE and COMMIT, and o_done high only in DONE.
REQ-027 SHALL register all outputs.

Reset
REQ-028 Assertion of i_rst_n low SHALL immediately force, at any point including mid-sweep: state=IDLE, o_tune_code all 0, o_lock all 0, o_pwr_req=0, o_pwr_sel=0, o_busy=0, o_done=0.
REQ-029 After reset release, SHALL take no action until i_start.

Configuration
REQ-030 With macro RING_TUNE_TRACK_EN defined, DONE SHALL track continuously, round-robin over the locked rings, one step per ring.
REQ-031 Each tracking step SHALL settle, measure at code+dir with saturation, adopt the new code only if its power exceeds the stored power, and otherwise restore the old code and invert dir; dir SHALL reset to +1.
REQ-032 Without RING_TUNE_TRACK_EN, DONE SHALL be static, with o_pwr_req=0 and codes frozen.

Structure
REQ-033 The state enum and the default parameter constants SHALL be placed in wdm_pkg.
REQ-034 The peak-search datapath (best_pwr/best_code registers and comparator) SHALL be one sub-module, ring_peak_search.

Verification
REQ-035 Peak at 100: with NUM_CHANNEL=2, TUNE_WIDTH=8, a ring model whose power peaks (1000) at code 100 for ch0 and at code 37 for ch1 -> final o_tune_code={37,100}, o_lock=2'b11, o_done=1.
REQ-036 Flat tie: constant power 500 at every code -> committed code 0, lock=1.
REQ-037 Dark ring: all power <16 on ch1 -> o_lock[1]=0 and its code is the strict maximum.
REQ-038 Stalled ADC: i_pwr_valid held low for 50 cycles in MEASURE -> o_pwr_req held, code unchanged, no advance.
REQ-039 Mid-sweep reset: drop i_rst_n at ch0 code 60 -> all outputs 0 the same cycle; re-start -> the sweep restarts at ch0 code 0.
REQ-040 RING_TUNE_TRACK_EN: shift the ch0 peak from 100 to 103 after DONE -> o_tune_code[0] reaches 103 within 4 tracking visits.

Source files
------------

// File: rtl/wdm_pkg.sv
// rtl/wdm_pkg.sv - shared state encodings and default parameters for ring tuning
package wdm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        COMMIT,
        DONE
    } tune_state_t;

    // Sub-phases of the optional tracking loop that runs while in DONE
    typedef enum logic [2:0] {
        TRK_PICK,
        TRK_BASE_SETTLE,
        TRK_BASE_MEAS,
        TRK_TRY_SETTLE,
        TRK_TRY_MEAS
    } trk_phase_t;

    localparam int DEF_NUM_CHANNEL   = 8;
    localparam int DEF_TUNE_WIDTH    = 8;
    localparam int DEF_PWR_WIDTH     = 10;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_LOCK_THRESH   = 16;

endpackage

// File: rtl/ring_peak_search.sv
// rtl/ring_peak_search.sv - running maximum of drop power and the code where it first occurred
module ring_peak_search
    import wdm_pkg::*;
#(
    parameter int TUNE_WIDTH = DEF_TUNE_WIDTH,
    parameter int PWR_WIDTH  = DEF_PWR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_sample,
    input  logic [PWR_WIDTH-1:0]  i_pwr,
    input  logic [TUNE_WIDTH-1:0] i_code,
    output logic [PWR_WIDTH-1:0]  o_best_pwr,
    output logic [TUNE_WIDTH-1:0] o_best_code
);

    // Strict comparison keeps the lowest code on a tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_best_pwr  <= '0;
            o_best_code <= '0;
        end else if (i_clear) begin
            o_best_pwr  <= '0;
            o_best_code <= '0;
        end else if (i_sample && (i_pwr > o_best_pwr)) begin
            o_best_pwr  <= i_pwr;
            o_best_code <= i_code;
        end
    end

endmodule

// File: rtl/ring_tune_ctrl.sv
// rtl/ring_tune_ctrl.sv - sweeps each ring's tuning code, commits the peak, flags lock
// Optional drift tracking in DONE is enabled by defining RING_TUNE_TRACK_EN.
module ring_tune_ctrl
    import wdm_pkg::*;
#(
    parameter int NUM_CHANNEL   = DEF_NUM_CHANNEL,
    parameter int TUNE_WIDTH    = DEF_TUNE_WIDTH,
    parameter int PWR_WIDTH     = DEF_PWR_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LOCK_THRESH   = DEF_LOCK_THRESH
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    output logic                              o_pwr_req,
    output logic [$clog2(NUM_CHANNEL)-1:0]    o_pwr_sel,
    input  logic                              i_pwr_valid,
    input  logic [PWR_WIDTH-1:0]              i_pwr_code,
    output logic [NUM_CHANNEL*TUNE_WIDTH-1:0] o_tune_code,
    output logic [NUM_CHANNEL-1:0]            o_lock,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int SEL_W = $clog2(NUM_CHANNEL);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TUNE_WIDTH-1:0] CODE_MAX    = '1;
    localparam logic [PWR_WIDTH-1:0]  LOCK_LVL    = PWR_WIDTH'(LOCK_THRESH);
    localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0]      CH_LAST     = SEL_W'(NUM_CHANNEL - 1);

    tune_state_t           state;
    tune_state_t           state_next;
    logic [SEL_W-1:0]      channel;
    logic [TUNE_WIDTH-1:0] code;
    logic [CNT_W-1:0]      settle_cnt;
    logic [PWR_WIDTH-1:0]  best_pwr;
    logic [TUNE_WIDTH-1:0] best_code;
    logic                  accept;
    logic                  settle_last;
    logic                  peak_clear;

    assign accept      = o_pwr_req & i_pwr_valid;
    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign peak_clear  = (((state == IDLE) || (state == DONE)) && i_start) || (state == COMMIT);

    ring_peak_search #(
        .TUNE_WIDTH (TUNE_WIDTH),
        .PWR_WIDTH  (PWR_WIDTH)
    ) u_peak (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (peak_clear),
        .i_sample    (accept && (state == MEASURE)),
        .i_pwr       (i_pwr_code),
        .i_code      (code),
        .o_best_pwr  (best_pwr),
        .o_best_code (best_code)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = SETTLE;
            SETTLE:  if (settle_last) state_next = MEASURE;
            MEASURE: if (accept) state_next = (code == CODE_MAX) ? COMMIT : SETTLE;
            COMMIT:  state_next = (channel == CH_LAST) ? DONE : SETTLE;
            DONE:    if (i_start) state_next = SETTLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef RING_TUNE_TRACK_EN
    trk_phase_t            trk_phase;
    logic [SEL_W-1:0]      trk_ch;
    logic [SEL_W-1:0]      trk_next_ch;
    logic                  trk_any;
    logic [NUM_CHANNEL-1:0] dir;
    logic [PWR_WIDTH-1:0]  base_pwr;
    logic [TUNE_WIDTH-1:0] old_code;
    logic [TUNE_WIDTH-1:0] trk_code;
    logic [TUNE_WIDTH-1:0] trk_trial;

    assign trk_code = o_tune_code[int'(trk_ch)*TUNE_WIDTH +: TUNE_WIDTH];

    // Nearest locked ring after trk_ch, wrapping; trk_ch itself is the last resort
    always_comb begin
        int idx;
        trk_next_ch = trk_ch;
        trk_any     = 1'b0;
        for (int k = NUM_CHANNEL; k >= 1; k--) begin
            idx = (int'(trk_ch) + k) % NUM_CHANNEL;
            if (o_lock[idx]) begin
                trk_next_ch = SEL_W'(idx);
                trk_any     = 1'b1;
            end
        end
    end

    always_comb begin
        trk_trial = trk_code;
        if (dir[trk_ch]) begin
            if (trk_code != '0) trk_trial = trk_code - 1'b1;
        end else if (trk_code != CODE_MAX) begin
            trk_trial = trk_code + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            channel     <= '0;
            code        <= '0;
            settle_cnt  <= '0;
            o_tune_code <= '0;
            o_lock      <= '0;
            o_pwr_req   <= 1'b0;
            o_pwr_sel   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
`ifdef RING_TUNE_TRACK_EN
            trk_phase   <= TRK_PICK;
            trk_ch      <= CH_LAST;
            dir         <= '0;
            base_pwr    <= '0;
            old_code    <= '0;
`endif
        end else begin
            o_busy     <= (state_next == SETTLE) || (state_next == MEASURE) || (state_next == COMMIT);
            o_done     <= (state_next == DONE);
            o_pwr_req  <= (state_next == MEASURE);
            settle_cnt <= ((state == SETTLE) && !settle_last) ? settle_cnt + 1'b1 : '0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        channel     <= '0;
                        code        <= '0;
                        o_tune_code <= '0;
                        o_lock      <= '0;
                        o_pwr_sel   <= '0;
`ifdef RING_TUNE_TRACK_EN
                        trk_phase   <= TRK_PICK;
                        trk_ch      <= CH_LAST;
                        dir         <= '0;
`endif
                    end
`ifdef RING_TUNE_TRACK_EN
                    // A fresh baseline is taken each step because the stored peak goes stale under drift
                    else if (state == DONE) begin
                        case (trk_phase)
                            TRK_PICK: begin
                                if (trk_any) begin
                                    trk_ch    <= trk_next_ch;
                                    o_pwr_sel <= trk_next_ch;
                                    trk_phase <= TRK_BASE_SETTLE;
                                end
                            end
                            TRK_BASE_SETTLE, TRK_TRY_SETTLE: begin
                                if (settle_last) begin
                                    o_pwr_req <= 1'b1;
                                    trk_phase <= (trk_phase == TRK_BASE_SETTLE) ? TRK_BASE_MEAS : TRK_TRY_MEAS;
                                end else begin
                                    settle_cnt <= settle_cnt + 1'b1;
                                end
                            end
                            TRK_BASE_MEAS: begin
                                o_pwr_req <= ~accept;
                                if (accept) begin
                                    base_pwr  <= i_pwr_code;
                                    old_code  <= trk_code;
                                    o_tune_code[int'(trk_ch)*TUNE_WIDTH +: TUNE_WIDTH] <= trk_trial;
                                    trk_phase <= TRK_TRY_SETTLE;
                                end
                            end
                            TRK_TRY_MEAS: begin
                                o_pwr_req <= ~accept;
                                if (accept) begin
                                    if (i_pwr_code <= base_pwr) begin
                                        o_tune_code[int'(trk_ch)*TUNE_WIDTH +: TUNE_WIDTH] <= old_code;
                                        dir[trk_ch] <= ~dir[trk_ch];
                                    end
                                    trk_phase <= TRK_PICK;
                                end
                            end
                            default: trk_phase <= TRK_PICK;
                        endcase
                    end
`endif
                end
                MEASURE: begin
                    if (accept && (code != CODE_MAX)) begin
                        code <= code + 1'b1;
                        o_tune_code[int'(channel)*TUNE_WIDTH +: TUNE_WIDTH] <= code + 1'b1;
                    end
                end
                COMMIT: begin
                    o_tune_code[int'(channel)*TUNE_WIDTH +: TUNE_WIDTH] <= best_code;
                    o_lock[channel] <= (best_pwr >= LOCK_LVL);
                    if (channel != CH_LAST) begin
                        channel   <= channel + 1'b1;
                        o_pwr_sel <= channel + 1'b1;
                        code      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_tune_ctrl.sv
// tb/tb_ring_tune_ctrl.sv - table-driven calibration runs with a ring/ADC model and scoreboard
module tb_ring_tune_ctrl;

    localparam int NCH = 2;
    localparam int TW  = 8;
    localparam int PW  = 10;
    localparam int SC  = 4;
    localparam int LT  = 16;

    localparam int M_PEAK = 0;
    localparam int M_FLAT = 1;
    localparam int M_DARK = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pwr_valid = 1'b0;
    logic [PW-1:0]     pwr_code = '0;
    logic              pwr_req;
    logic [0:0]        pwr_sel;
    logic [NCH*TW-1:0] tune_code;
    logic [NCH-1:0]    lock;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    ring_tune_ctrl #(
        .NUM_CHANNEL   (NCH),
        .TUNE_WIDTH    (TW),
        .PWR_WIDTH     (PW),
        .SETTLE_CYCLES (SC),
        .LOCK_THRESH   (LT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_pwr_req   (pwr_req),
        .o_pwr_sel   (pwr_sel),
        .i_pwr_valid (pwr_valid),
        .i_pwr_code  (pwr_code),
        .o_tune_code (tune_code),
        .o_lock      (lock),
        .o_busy      (busy),
        .o_done      (done)
    );

    int   checks = 0;
    int   failures = 0;
    int   ring_mode [NCH];
    int   ring_peak [NCH];
    logic stall = 1'b0;
    int   lat = 0;

    typedef struct {
        logic [TW-1:0] code;
        logic          lk;
    } exp_t;
    exp_t sbq [$];

    typedef struct {
        string         name;
        int            mode0;
        int            peak0;
        int            mode1;
        int            peak1;
        logic [TW-1:0] exp0;
        logic [TW-1:0] exp1;
        logic [1:0]    lk;
    } vec_t;
    vec_t vecs [4];

    function automatic int ring_power(input int ch, input int c);
        int d;
        case (ring_mode[ch])
            M_FLAT:  return 500;
            M_DARK:  return (c * 37 + 11) % 15;
            default: begin
                d = (c > ring_peak[ch]) ? c - ring_peak[ch] : ring_peak[ch] - c;
                return 1000 - 3 * d;
            end
        endcase
    endfunction

    function automatic int tcode(input int ch);
        return int'(tune_code[ch*TW +: TW]);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ADC model: answers requests after 0..3 cycles, throws junk strobes while idle
    always @(negedge clk) begin
        if (!rst_n || stall) begin
            pwr_valid = 1'b0;
        end else if (pwr_req) begin
            if (lat == 0) begin
                pwr_valid = 1'b1;
                pwr_code  = PW'(ring_power(int'(pwr_sel), tcode(int'(pwr_sel))));
                lat       = $urandom_range(0, 3);
            end else begin
                pwr_valid = 1'b0;
                lat--;
            end
        end else begin
            pwr_valid = ($urandom_range(0, 3) == 0);
            pwr_code  = '1;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_calib(input int t);
        int   n;
        exp_t e;
        ring_mode[0] = vecs[t].mode0;
        ring_peak[0] = vecs[t].peak0;
        ring_mode[1] = vecs[t].mode1;
        ring_peak[1] = vecs[t].peak1;
        sbq.push_back('{vecs[t].exp0, vecs[t].lk[0]});
        sbq.push_back('{vecs[t].exp1, vecs[t].lk[1]});
        pulse_start();
        check({vecs[t].name, "_restart_codes"}, int'(tune_code), 0);
        check({vecs[t].name, "_restart_lock"}, int'(lock), 0);
        check({vecs[t].name, "_busy"}, int'(busy), 1);
        n = 0;
        while (!done && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check({vecs[t].name, "_done"}, int'(done), 1);
        check({vecs[t].name, "_busy_off"}, int'(busy), 0);
        for (int ch = 0; ch < NCH; ch++) begin
            e = sbq.pop_front();
            check($sformatf("%s_code%0d", vecs[t].name, ch), tcode(ch), int'(e.code));
            check($sformatf("%s_lock%0d", vecs[t].name, ch), int'(lock[ch]), int'(e.lk));
        end
    endtask

    initial begin
        int   n;
        logic ok_req;
        logic [NCH*TW-1:0] snap;

        vecs[0] = '{"peak_100_37", M_PEAK, 100, M_PEAK, 37, 8'd100, 8'd37, 2'b11};
        vecs[1] = '{"flat_tie", M_FLAT, 0, M_FLAT, 0, 8'd0, 8'd0, 2'b11};
        vecs[2] = '{"dark_ch1", M_PEAK, 200, M_DARK, 0, 8'd200, 8'd9, 2'b01};
        vecs[3] = '{"edge_codes", M_PEAK, 255, M_PEAK, 0, 8'd255, 8'd0, 2'b11};

        repeat (3) @(negedge clk);
        check("rst_tune", int'(tune_code), 0);
        check("rst_lock", int'(lock), 0);
        check("rst_req", int'(pwr_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_action", int'({busy, done, pwr_req}), 0);

        // Settle length, stalled ADC and the re-settle gap after one step
        ring_mode[0] = M_PEAK; ring_peak[0] = 100;
        ring_mode[1] = M_PEAK; ring_peak[1] = 37;
        stall = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!pwr_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("settle_cycles", n, SC);
        ok_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok_req = ok_req & pwr_req & busy;
        end
        check("stall_req_held", int'(ok_req), 1);
        check("stall_code", tcode(0), 0);
        check("stall_sel", int'(pwr_sel), 0);
        stall = 1'b0;
        n = 0;
        while (tcode(0) != 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_step", tcode(0), 1);
        n = 0;
        while (!pwr_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("resettle_gap", n, SC);

        n = 0;
        while (tcode(0) != 60 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_60", tcode(0), 60);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tune", int'(tune_code), 0);
        check("midrst_flags", int'({lock, pwr_req, pwr_sel, busy, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_idle", int'({busy, done, pwr_req}), 0);

        for (int t = 0; t < 4; t++) begin
            run_calib(t);
            if (t == 0) begin
`ifdef RING_TUNE_TRACK_EN
                ring_peak[0] = 103;
                n = 0;
                while (tcode(0) != 103 && n < 170) begin
                    @(negedge clk);
                    n++;
                end
                check("track_ch0", tcode(0), 103);
                check("track_ch1", tcode(1), 37);
                check("track_lock", int'(lock), 3);
`else
                snap = tune_code;
                ok_req = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    ok_req = ok_req | pwr_req;
                end
                check("static_codes", int'(tune_code), int'(snap));
                check("static_req", int'(ok_req), 0);
                check("static_done", int'(done), 1);
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
